beep_pattern_gen: RTL and testbench
===================================

# beep_pattern_gen

- Output-side counterpart to the button input conditioning in the timer/stopwatch design.
- Converts a single-cycle event pulse (e.g. countdown expiry, debounced button press) into a timed, human-perceptible pattern:
  - BEEP_COUNT beeps of ON_MS on and OFF_MS off.
  - A square-wave tone at TONE_HZ for a piezo buzzer, and an envelope level for an LED.
- Sits between the timer control FSM and the board's buzzer/LED pins.

## Interface
- CLK_FREQ, 100_000_000, clock frequency in Hz; CPM = CLK_FREQ/1000 cycles per ms.
- ON_MS, 100, beep on-duration in ms (>=1).
- OFF_MS, 100, gap between beeps in ms (>=1).
- BEEP_COUNT, 3, beeps per pattern (>=1).
- TONE_HZ, 2000, tone frequency; half-period HP = CLK_FREQ/(2*TONE_HZ) cycles (>=1).
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- trigger  input  1  single-cycle start request, synchronous to clk.
- cancel  input  1  synchronous abort request.
- tone_out  output  1  buzzer drive, square wave during ON, else 0.
- env_out  output  1  high during ON phases (LED).
- busy  output  1  high in ON or OFF.
- done  output  1  one-cycle pulse on normal pattern completion.

## Operation
- States:
  - IDLE:
    - trigger -> ON; beep_idx=1; phase counter cleared; tone phase reset.
  - ON:
    - Held for exactly ON_MS*CPM cycles.
    - At the end: if beep_idx==BEEP_COUNT -> IDLE with done=1; else -> OFF.
  - OFF:
    - Held for exactly OFF_MS*CPM cycles.
    - At the end -> ON, beep_idx+1, tone phase reset.
- Priority: reset > cancel > trigger > phase timeout.
- cancel in ON/OFF: -> IDLE next edge, no done pulse. cancel in IDLE: no effect.
- trigger and cancel in the same cycle: cancel wins; the trigger is discarded.
- trigger while busy: behaviour set by Configuration.
- Phase counter width is $clog2(max(ON_MS,OFF_MS)*CPM + 1). It counts from 0 and never wraps.
- beep_idx width is $clog2(BEEP_COUNT + 1).
- Tone generation:
  - Tone counter counts 0..HP-1.
  - tone_out is 1 on the first ON cycle of each beep and toggles after every HP ON cycles.
  - tone_out is forced to 0 in IDLE/OFF.
- All outputs are registered. Reset value of tone_out, env_out, busy, done is 0; state is IDLE.

## Timing
- trigger sampled at edge k -> env_out, busy, tone_out = 1 from cycle k+1. Latency is 1 cycle.
- env_out high for exactly ON_MS*CPM consecutive cycles per beep, low for exactly OFF_MS*CPM between beeps.
- After the final ON phase there is no trailing OFF:
  - done=1 and busy=0 on the cycle immediately after the last ON cycle.
  - done lasts exactly 1 cycle.
- Pattern length = BEEP_COUNT*ON_MS*CPM + (BEEP_COUNT-1)*OFF_MS*CPM cycles.
- A trigger sampled in the same cycle done is high is accepted; the next pattern starts the following cycle.
- Asynchronous reset mid-pattern: all outputs 0 immediately, no done pulse.

## Configuration
- BEEP_RETRIGGER_EN defined:
  - trigger while busy restarts the pattern next edge: ON, beep_idx=1, counters cleared, tone phase reset.
  - The aborted pattern emits no done.
  - Trigger on the final ON cycle also restarts; done is suppressed.
- BEEP_RETRIGGER_EN undefined:
  - trigger while busy is ignored.
  - The running pattern completes normally with its done pulse.

## Test plan
Parameters for all directed tests: CLK_FREQ=10_000 (CPM=10), ON_MS=2, OFF_MS=1, BEEP_COUNT=2, TONE_HZ=1000 (HP=5); trigger is high during cycle 0.

- Basic pattern:
  - env_out high cycles 1–20, low 21–30, high 31–50.
  - tone_out high 1–5, low 6–10, high 11–15, low 16–20, then high again from 31.
  - done=1 only at cycle 51, busy=0 from 51.
- Cancel at cycle 10 -> all outputs 0 from cycle 11; no done ever.
- Retrigger at cycle 25 (OFF phase):
  - Macro undefined -> identical to basic pattern, done at 51.
  - Macro defined -> env_out high 26–45, low 46–55, high 56–75; done only at 76.
- trigger and cancel both high at cycle 0 in IDLE -> busy stays 0, no outputs for 100 cycles.
- reset asserted asynchronously mid-cycle 12 -> tone_out/env_out/busy drop to 0 before the next edge. After release, trigger produces a fresh basic pattern.
- Back-to-back: second trigger during cycle 51 (done cycle) -> env_out high again cycles 52–71, second done at cycle 102.

Source files
------------

// File: rtl/beep_pattern_gen.sv
// Turns a one-cycle trigger into BEEP_COUNT timed beeps: square-wave tone for a buzzer plus an LED envelope.
// Optional feature macro: BEEP_RETRIGGER_EN (trigger while busy restarts the pattern).
module beep_pattern_gen #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned ON_MS      = 100,
    parameter int unsigned OFF_MS     = 100,
    parameter int unsigned BEEP_COUNT = 3,
    parameter int unsigned TONE_HZ    = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    input  logic cancel,
    output logic tone_out,
    output logic env_out,
    output logic busy,
    output logic done
);

    localparam int unsigned CPM     = CLK_FREQ / 1000;
    localparam int unsigned ON_CYC  = ON_MS * CPM;
    localparam int unsigned OFF_CYC = OFF_MS * CPM;
    localparam int unsigned MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int unsigned HP      = CLK_FREQ / (2 * TONE_HZ);
    localparam int          CW      = $clog2(MAX_CYC + 1);
    localparam int          IW      = $clog2(BEEP_COUNT + 1);
    localparam int          TW      = (HP > 1) ? $clog2(HP) : 1;

    localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(BEEP_COUNT);
    localparam logic [TW-1:0] TONE_LAST = TW'(HP - 1);

`ifdef BEEP_RETRIGGER_EN
    localparam logic RETRIG = 1'b1;
`else
    localparam logic RETRIG = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] phase_cnt, phase_next;
    logic [IW-1:0] beep_idx, idx_next;
    logic [TW-1:0] tone_cnt, tcnt_next;
    logic          tone_next;
    logic          done_next;
    logic          start;

    // Next-state logic; a start (fresh or retrigger) overrides everything except cancel.
    always_comb begin
        state_next = state;
        phase_next = phase_cnt;
        idx_next   = beep_idx;
        tcnt_next  = tone_cnt;
        tone_next  = 1'b0;
        done_next  = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (trigger && !cancel) begin
                    start = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            ON: begin
                if (cancel) begin
                    state_next = IDLE;
                end else if (trigger && RETRIG) begin
                    start = 1'b1;
                end else if (phase_cnt == ON_LAST) begin
                    phase_next = '0;
                    if (beep_idx == IDX_LAST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = OFF;
                    end
                end else begin
                    phase_next = phase_cnt + CW'(1);
                    // tone_out holds the current tone level while ON
                    if (tone_cnt == TONE_LAST) begin
                        tcnt_next = '0;
                        tone_next = ~tone_out;
                    end else begin
                        tcnt_next = tone_cnt + TW'(1);
                        tone_next = tone_out;
                    end
                end
            end
            OFF: begin
                if (cancel) begin
                    state_next = IDLE;
                end else if (trigger && RETRIG) begin
                    start = 1'b1;
                end else if (phase_cnt == OFF_LAST) begin
                    state_next = ON;
                    phase_next = '0;
                    idx_next   = beep_idx + IW'(1);
                    tcnt_next  = '0;
                    tone_next  = 1'b1;
                end else begin
                    phase_next = phase_cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (start) begin
            state_next = ON;
            phase_next = '0;
            idx_next   = IW'(1);
            tcnt_next  = '0;
            tone_next  = 1'b1;
        end else begin
            state_next = state_next;
        end
    end

    // State and registered outputs, all derived from the next-state values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            beep_idx  <= '0;
            tone_cnt  <= '0;
            tone_out  <= 1'b0;
            env_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_next;
            beep_idx  <= idx_next;
            tone_cnt  <= tcnt_next;
            tone_out  <= tone_next;
            env_out   <= (state_next == ON);
            busy      <= (state_next != IDLE);
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Scoreboard bench for beep_pattern_gen: a time-offset reference model predicts each cycle's outputs.
module tb_beep_pattern_gen;

    localparam int unsigned CLK_FREQ   = 10_000;
    localparam int unsigned ON_MS      = 2;
    localparam int unsigned OFF_MS     = 1;
    localparam int unsigned BEEP_COUNT = 2;
    localparam int unsigned TONE_HZ    = 1000;

    localparam int CPM    = CLK_FREQ / 1000;
    localparam int ON_C   = ON_MS * CPM;
    localparam int OFF_C  = OFF_MS * CPM;
    localparam int PERIOD = ON_C + OFF_C;
    localparam int TOTAL  = BEEP_COUNT * ON_C + (BEEP_COUNT - 1) * OFF_C;
    localparam int HPC    = CLK_FREQ / (2 * TONE_HZ);

`ifdef BEEP_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic trigger;
    logic cancel;
    logic tone_out;
    logic env_out;
    logic busy;
    logic done;

    typedef struct packed {
        logic env;
        logic tone;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    int   done_seen[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    // Reference model: whether a pattern is running and how many cycles into it we are.
    bit m_active = 1'b0;
    int m_t = 0;

    beep_pattern_gen #(
        .CLK_FREQ(CLK_FREQ),
        .ON_MS(ON_MS),
        .OFF_MS(OFF_MS),
        .BEEP_COUNT(BEEP_COUNT),
        .TONE_HZ(TONE_HZ)
    ) dut (
        .clk(clk),
        .reset(reset),
        .trigger(trigger),
        .cancel(cancel),
        .tone_out(tone_out),
        .env_out(env_out),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Predicts the outputs visible after the coming clock edge and queues them.
    task automatic model_step(input bit trig, input bit canc, input bit rst);
        exp_t e;
        int   u;
        bit   d;
        d = 1'b0;
        if (rst) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (canc) m_active = 1'b0;
            else if (trig && RETRIG) m_t = 0;
            else if (m_t == TOTAL - 1) begin
                m_active = 1'b0;
                d = 1'b1;
            end else m_t++;
        end else if (trig && !canc) begin
            m_active = 1'b1;
            m_t = 0;
        end
        u = m_t % PERIOD;
        e.busy = m_active;
        e.env  = m_active && (u < ON_C);
        e.tone = e.env && (((u / HPC) % 2) == 0);
        e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit trig, input bit canc, input bit rst);
        @(negedge clk);
        trigger = trig;
        cancel  = canc;
        reset   = rst;
        model_step(trig, canc, rst);
    endtask

    task automatic run_idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle the DUT presents outputs, pop the prediction and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done === 1'b1) done_seen.push_back(cyc);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs{env,tone,busy,done}", int'({env_out, tone_out, busy, done}), int'(e));
        end
    end

    initial begin
        int t0;
        reset   = 1'b1;
        trigger = 1'b0;
        cancel  = 1'b0;
        #2;
        chk("reset_tone", int'(tone_out), 0);
        chk("reset_env", int'(env_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        run_idle(3);

        // Basic pattern
        settle(); done_seen.delete();
        step(1'b1, 1'b0, 1'b0); t0 = cyc;
        run_idle(60); settle();
        chk("basic_done_count", done_seen.size(), 1);
        if (done_seen.size() > 0) chk("basic_done_cycle", done_seen[0] - t0, 51);

        // Cancel during the first beep
        done_seen.delete();
        step(1'b1, 1'b0, 1'b0);
        run_idle(9);
        step(1'b0, 1'b1, 1'b0);
        run_idle(60); settle();
        chk("cancel_no_done", done_seen.size(), 0);

        // Trigger during the OFF gap
        done_seen.delete();
        step(1'b1, 1'b0, 1'b0); t0 = cyc;
        run_idle(24);
        step(1'b1, 1'b0, 1'b0);
        run_idle(90); settle();
        chk("retrig_done_count", done_seen.size(), 1);
        if (done_seen.size() > 0) chk("retrig_done_cycle", done_seen[0] - t0, RETRIG ? 76 : 51);

        // Trigger and cancel together in IDLE
        done_seen.delete();
        step(1'b1, 1'b1, 1'b0);
        run_idle(100); settle();
        chk("trig_cancel_no_done", done_seen.size(), 0);

        // Asynchronous reset in the middle of cycle 12
        step(1'b1, 1'b0, 1'b0);
        run_idle(11);
        @(posedge clk);
        #3;
        reset = 1'b1;
        m_active = 1'b0;
        #1;
        chk("async_rst_tone", int'(tone_out), 0);
        chk("async_rst_env", int'(env_out), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        settle(); done_seen.delete();
        step(1'b1, 1'b0, 1'b0); t0 = cyc;
        run_idle(60); settle();
        chk("post_reset_done_count", done_seen.size(), 1);
        if (done_seen.size() > 0) chk("post_reset_done_cycle", done_seen[0] - t0, 51);

        // Back-to-back: second trigger on the done cycle
        done_seen.delete();
        step(1'b1, 1'b0, 1'b0); t0 = cyc;
        run_idle(50);
        step(1'b1, 1'b0, 1'b0);
        run_idle(110); settle();
        chk("b2b_done_count", done_seen.size(), 2);
        if (done_seen.size() > 1) begin
            chk("b2b_done1_cycle", done_seen[0] - t0, 51);
            chk("b2b_done2_cycle", done_seen[1] - t0, 102);
        end

        // Random triggers, cancels and occasional resets
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 999) == 0);
        end
        step(1'b0, 1'b0, 1'b0);
        settle();
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
